// File: rtl/dmem_pkg.sv
// Shared definitions for the RV64I load/store sequencer: funct3 encodings,
// FSM state type, latched request record and the natural-alignment rule.
package dmem_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_D  = 3'b011;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;
    localparam logic [2:0] LS_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LD_WAIT  = 2'd1,
        ST_MERGE = 2'd2
    } dmem_state_t;

    // Request fields captured when a two-cycle access is accepted.
    typedef struct packed {
        logic [2:0]  funct3;
        logic [2:0]  off;
        logic [63:0] wdata;
    } dmem_req_t;

    // size is funct3[1:0]: 0 byte, 1 half, 2 word, 3 double.
    function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off);
        logic ok;
        case (size)
            2'd0:    ok = 1'b1;
            2'd1:    ok = (off[0] == 1'b0);
            2'd2:    ok = (off[1:0] == 2'b00);
            default: ok = (off == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Pipeline-side MEM-stage bus between the core and the load/store sequencer.
interface dmem_if;

    // Handshake: MemRead_M/MemWrite_M act as the request valid; Stall_M=0 is
    // ready. While Stall_M=1 the master must hold every request field stable;
    // the request completes in the first cycle Stall_M=0 is seen with it.
    logic        MemRead_M;
    logic        MemWrite_M;
    logic [2:0]  Funct3_M;
    logic [63:0] ALUResult_M;
    logic [63:0] WriteData_M;
    logic [63:0] ReadData_M;
    logic        Stall_M;
    logic        Misalign_M;

    modport master (
        output MemRead_M,
        output MemWrite_M,
        output Funct3_M,
        output ALUResult_M,
        output WriteData_M,
        input  ReadData_M,
        input  Stall_M,
        input  Misalign_M
    );

    modport slave (
        input  MemRead_M,
        input  MemWrite_M,
        input  Funct3_M,
        input  ALUResult_M,
        input  WriteData_M,
        output ReadData_M,
        output Stall_M,
        output Misalign_M
    );

endinterface

// File: rtl/dmem_lane.sv
// Combinational byte-lane logic: sub-word load extract/extend and
// sub-word store merge into a previously read doubleword.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [2:0]  off_i,
    input  logic [63:0] rdata_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] load_o,
    output logic [63:0] merge_o
);

    function automatic logic [63:0] load_extend(input logic [63:0] dw,
                                                input logic [2:0]  f3,
                                                input logic [2:0]  off);
        logic [63:0] sh;
        logic [63:0] res;
        sh = dw >> {off, 3'b000};
        case (f3)
            LS_B:    res = {{56{sh[7]}},  sh[7:0]};
            LS_H:    res = {{48{sh[15]}}, sh[15:0]};
            LS_W:    res = {{32{sh[31]}}, sh[31:0]};
            LS_BU:   res = {56'd0, sh[7:0]};
            LS_HU:   res = {48'd0, sh[15:0]};
            LS_WU:   res = {32'd0, sh[31:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    // Bytes off..off+size-1 come from the right-aligned store data.
    function automatic logic [63:0] store_merge(input logic [63:0] dw,
                                                input logic [63:0] wd,
                                                input logic [1:0]  size,
                                                input logic [2:0]  off);
        logic [7:0]  be;
        logic [63:0] wsh;
        logic [63:0] res;
        case (size)
            2'd0:    be = 8'h01;
            2'd1:    be = 8'h03;
            2'd2:    be = 8'h0F;
            default: be = 8'hFF;
        endcase
        be  = be << off;
        wsh = wd << {off, 3'b000};
        for (int i = 0; i < 8; i++) begin
            res[8*i +: 8] = be[i] ? wsh[8*i +: 8] : dw[8*i +: 8];
        end
        return res;
    endfunction

    always_comb begin
        load_o  = load_extend(rdata_i, funct3_i, off_i);
        merge_o = store_merge(rdata_i, wdata_i, funct3_i[1:0], off_i);
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store sequencer between EX/MEM and a single-port, word-addressed,
// synchronous-read 64-bit data memory without byte enables.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    dmem_if.slave             bus,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata,
    output dmem_state_t       dbg_state_o
);

    dmem_state_t      state_q, state_d;
    dmem_req_t        req_q, req_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic        req_any;
    logic        req_store;
    logic        req_dword;
    logic [2:0]  req_off;
    logic        req_ok;
    logic        stall;
    logic        misalign;
    logic        we;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic [63:0] lane_load;
    logic [63:0] lane_merge;
    logic        unused_addr_bits;

    // Upper address bits fall outside the memory and simply wrap.
    assign mem_addr         = bus.ALUResult_M[ADDR_W+2:3];
    assign unused_addr_bits = ^bus.ALUResult_M[63:ADDR_W+3];

    assign req_any   = bus.MemWrite_M | bus.MemRead_M;
    assign req_store = bus.MemWrite_M;
    assign req_dword = (bus.Funct3_M[1:0] == LS_D[1:0]);
    assign req_off   = bus.ALUResult_M[2:0];
    assign req_ok    = is_aligned(bus.Funct3_M[1:0], req_off);

    dmem_lane u_lane (
        .funct3_i (req_q.funct3),
        .off_i    (req_q.off),
        .rdata_i  (mem_rdata),
        .wdata_i  (req_q.wdata),
        .load_o   (lane_load),
        .merge_o  (lane_merge)
    );

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        stall    = 1'b0;
        misalign = 1'b0;
        we       = 1'b0;
        wdata    = 64'd0;
        rdata    = 64'd0;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    if (!req_ok) begin
                        misalign = 1'b1;
                    end else if (req_store && req_dword) begin
                        we    = 1'b1;
                        wdata = bus.WriteData_M;
                    end else begin
                        // Loads and sub-word stores both need the doubleword first.
                        stall   = 1'b1;
                        req_d   = '{funct3: bus.Funct3_M, off: req_off, wdata: bus.WriteData_M};
                        state_d = req_store ? ST_MERGE : LD_WAIT;
                    end
                end
            end
            LD_WAIT: begin
                rdata   = lane_load;
                state_d = IDLE;
            end
            ST_MERGE: begin
                we      = 1'b1;
                wdata   = lane_merge;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            stall    = 1'b0;
            misalign = 1'b0;
            we       = 1'b0;
            wdata    = 64'd0;
            rdata    = 64'd0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.Stall_M    = stall;
    assign bus.Misalign_M = misalign;
    assign bus.ReadData_M = rdata;
    assign mem_we         = we;
    assign mem_wdata      = wdata;
    assign StallCnt       = stall_cnt_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: transaction-level memory/latency model feeding an
// expected-cycle queue, one per-cycle compare process, plus literal spot checks.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_if bus ();
    logic [CNT_W-1:0]  stall_cnt;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [63:0]       mem_wdata;
    logic [63:0]       mem_rdata;
    dmem_state_t       dbg_state;

    dmem_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .StallCnt    (stall_cnt),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .dbg_state_o (dbg_state)
    );

    function automatic logic [63:0] pat(input int i);
        return 64'hF0E1D2C3B4A59687 ^ 64'(i);
    endfunction

    // Synchronous-read single-port memory seen by the DUT.
    logic [63:0] ram [0:DEPTH-1];
    logic        ram_init;
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= pat(i);
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic              stall;
        logic              mis;
        logic              we;
        logic              chk_cnt;
        logic [ADDR_W-1:0] addr;
        logic [63:0]       wdata;
        logic [63:0]       rdata;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    exp_t             exp_q[$];
    logic [63:0]      model_mem [0:DEPTH-1];
    logic [CNT_W-1:0] model_cnt;
    int               n_checks = 0;
    int               n_errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e.stall = 1'b0; e.mis = 1'b0; e.we = 1'b0; e.chk_cnt = 1'b1;
        e.addr = '0; e.wdata = 64'd0; e.rdata = 64'd0; e.cnt = '0;
        return e;
    endfunction

    // Load result from the architectural rule: shift, mask to size, extend.
    function automatic logic [63:0] m_load(input logic [63:0] dw, input logic [2:0] f3, input int off);
        int          nb;
        logic [63:0] mask;
        logic [63:0] v;
        nb   = 1 << f3[1:0];
        mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8*nb)) - 64'd1);
        v    = (dw >> (8*off)) & mask;
        if (!f3[2] && nb < 8 && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [63:0] m_merge(input logic [63:0] dw, input logic [63:0] wd,
                                            input int nb, input int off);
        logic [63:0] r;
        r = dw;
        for (int i = 0; i < nb; i++) r[8*(off+i) +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // One cycle of stimulus plus the outputs that cycle must show.
    task automatic drive(input logic rd, input logic wr, input logic rst, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wd, input exp_t e);
        @(posedge clk);
        #1;
        reset           = rst;
        bus.MemRead_M   = rd;
        bus.MemWrite_M  = wr;
        bus.Funct3_M    = f3;
        bus.ALUResult_M = addr;
        bus.WriteData_M = wd;
        e.addr = addr[ADDR_W+2:3];
        e.cnt  = model_cnt;
        exp_q.push_back(e);
        if (rst) model_cnt = '0;
        else if (e.stall && model_cnt != {CNT_W{1'b1}}) model_cnt = model_cnt + 1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0, zero_exp());
    endtask

    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] wd);
        exp_t e1, e2;
        int   off, nb, idx;
        off = int'(addr[2:0]);
        nb  = 1 << f3[1:0];
        idx = int'(addr[ADDR_W+2:3]);
        e1  = zero_exp();
        e2  = zero_exp();
        if (off % nb != 0) begin
            e1.mis = 1'b1;
            drive(rd, wr, 1'b0, f3, addr, wd, e1);
        end else if (wr && nb == 8) begin
            e1.we = 1'b1; e1.wdata = wd;
            drive(rd, wr, 1'b0, f3, addr, wd, e1);
            model_mem[idx] = wd;
        end else if (wr) begin
            e1.stall = 1'b1;
            drive(rd, wr, 1'b0, f3, addr, wd, e1);
            e2.we = 1'b1; e2.wdata = m_merge(model_mem[idx], wd, nb, off);
            drive(rd, wr, 1'b0, f3, addr, wd, e2);
            model_mem[idx] = e2.wdata;
        end else begin
            e1.stall = 1'b1;
            drive(rd, wr, 1'b0, f3, addr, wd, e1);
            e2.rdata = m_load(model_mem[idx], f3, off);
            drive(rd, wr, 1'b0, f3, addr, wd, e2);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("stall", 64'(bus.Stall_M), 64'(e.stall));
            check("misalign", 64'(bus.Misalign_M), 64'(e.mis));
            check("mem_we", 64'(mem_we), 64'(e.we));
            check("mem_addr", 64'(mem_addr), 64'(e.addr));
            check("rdata", bus.ReadData_M, e.rdata);
            if (e.we) check("mem_wdata", mem_wdata, e.wdata);
            if (e.chk_cnt) check("stall_cnt", 64'(stall_cnt), 64'(e.cnt));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t er;
        reset = 1'b1; ram_init = 1'b1;
        bus.MemRead_M = 1'b0; bus.MemWrite_M = 1'b0; bus.Funct3_M = 3'b000;
        bus.ALUResult_M = 64'd0; bus.WriteData_M = 64'd0;
        model_cnt = '0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = pat(i);

        er = zero_exp();
        er.chk_cnt = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 3'b000, 64'd0, 64'd0, er);
        ram_init = 1'b0;
        drive(1'b1, 1'b0, 1'b1, LS_D, 64'h10, 64'd0, er);
        idle();
        @(negedge clk); #1;
        check("reset_stallcnt", 64'(stall_cnt), 64'd0);
        check("reset_state", 64'(dbg_state), 64'(IDLE));

        // T1 sd
        access(1'b0, 1'b1, LS_D, 64'h10, 64'h1122334455667788);
        @(negedge clk); #1;
        check("T1_we", 64'(mem_we), 64'd1);
        check("T1_addr", 64'(mem_addr), 64'd2);
        check("T1_stall", 64'(bus.Stall_M), 64'd0);

        // T2 lb / lbu
        access(1'b1, 1'b0, LS_B, 64'h17, 64'd0);
        @(negedge clk); #1;
        check("T2_lb17", bus.ReadData_M, 64'h0000000000000011);
        access(1'b1, 1'b0, LS_B, 64'h10, 64'd0);
        @(negedge clk); #1;
        check("T2_lb10", bus.ReadData_M, 64'hFFFFFFFFFFFFFF88);
        access(1'b1, 1'b0, LS_BU, 64'h10, 64'd0);
        @(negedge clk); #1;
        check("T2_lbu10", bus.ReadData_M, 64'h0000000000000088);

        // T3 sh merge
        access(1'b0, 1'b1, LS_H, 64'h12, 64'h000000000000BEEF);
        @(negedge clk); #1;
        check("T3_wdata", mem_wdata, 64'h11223344BEEF7788);

        access(1'b1, 1'b0, LS_H, 64'h12, 64'd0);
        access(1'b1, 1'b0, LS_HU, 64'h12, 64'd0);
        access(1'b1, 1'b0, LS_W, 64'h14, 64'd0);
        access(1'b1, 1'b0, LS_WU, 64'h10, 64'd0);
        access(1'b1, 1'b0, LS_W, 64'h10, 64'd0);
        @(negedge clk); #1;
        check("lw10_sext", bus.ReadData_M, 64'hFFFFFFFFBEEF7788);
        access(1'b1, 1'b0, LS_D, 64'h10, 64'd0);

        // T4 misaligned accesses
        access(1'b1, 1'b0, LS_W, 64'h0A, 64'd0);
        @(negedge clk); #1;
        check("T4_misalign", 64'(bus.Misalign_M), 64'd1);
        access(1'b0, 1'b1, LS_H, 64'h13, 64'h1234);
        access(1'b0, 1'b1, LS_D, 64'h14, 64'h5555);
        access(1'b1, 1'b0, LS_D, 64'h0C, 64'd0);

        // Word store, wrapped-address byte store, store-wins, back-to-back
        access(1'b0, 1'b1, LS_W, 64'h1C, 64'hCAFEBABEDEADBEEF);
        access(1'b1, 1'b0, LS_D, 64'h18, 64'd0);
        access(1'b0, 1'b1, LS_B, 64'hFFFFFFFFFFFFE015, 64'h00000000000000A5);
        access(1'b1, 1'b0, LS_BU, 64'h15, 64'd0);
        @(negedge clk); #1;
        check("wrap_lbu", bus.ReadData_M, 64'h00000000000000A5);
        access(1'b1, 1'b1, LS_D, 64'h20, 64'h0123456789ABCDEF);
        access(1'b1, 1'b0, LS_D, 64'h20, 64'd0);
        access(1'b0, 1'b1, LS_B, 64'h21, 64'h0000000000000080);
        access(1'b1, 1'b0, LS_B, 64'h21, 64'd0);
        idle();

        // T5 reset during ST_MERGE
        er = zero_exp();
        er.stall = 1'b1;
        drive(1'b0, 1'b1, 1'b0, LS_B, 64'h30, 64'h00000000000000AB, er);
        er = zero_exp();
        er.chk_cnt = 1'b0;
        drive(1'b0, 1'b1, 1'b1, LS_B, 64'h30, 64'h00000000000000AB, er);
        @(negedge clk); #1;
        check("T5_we_in_reset", 64'(mem_we), 64'd0);
        idle();
        @(negedge clk); #1;
        check("T5_state", 64'(dbg_state), 64'(IDLE));
        check("T5_stallcnt", 64'(stall_cnt), 64'd0);
        access(1'b1, 1'b0, LS_D, 64'h30, 64'd0);
        @(negedge clk); #1;
        check("T5_no_write", bus.ReadData_M, 64'hF0E1D2C3B4A59681);

        // T6 saturating stall counter
        idle();
        @(negedge clk); #2;
        force dut.stall_cnt_q = 32'hFFFFFFFE;
        #1;
        release dut.stall_cnt_q;
        model_cnt = 32'hFFFFFFFE;
        idle();
        access(1'b1, 1'b0, LS_D, 64'h10, 64'd0);
        access(1'b1, 1'b0, LS_W, 64'h18, 64'd0);
        access(1'b1, 1'b0, LS_HU, 64'h22, 64'd0);
        idle();
        @(negedge clk); #1;
        check("T6_saturate", 64'(stall_cnt), 64'h00000000FFFFFFFF);

        @(negedge clk); #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
